// File: rtl/resp_frame_generator.sv
// Multi-channel ACK/NAK response frame generator with round-robin arbitration and backpressure.
// Build option RESP_NAK_CODE_EN appends a reason-code byte (LEN=1) to NAK frames.
module resp_frame_generator #(
  parameter int unsigned NUM_CH = 2,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     generate_ack,
  input  logic [NUM_CH-1:0]     generate_nak,
  input  logic [8*NUM_CH-1:0]   eid_in,
  input  logic [8*NUM_CH-1:0]   nak_code_in,
  input  logic                  message_data_ready,
  output logic [7:0]            message_data,
  output logic                  message_data_valid,
  output logic                  message_frame_valid,
  output logic [CH_W-1:0]       frame_channel,
  output logic [NUM_CH-1:0]     ch_pending,
  output logic [NUM_CH-1:0]     req_overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StType,
    StEid,
`ifdef RESP_NAK_CODE_EN
    StCode,
`endif
    StLen
  } state_e;

  state_e state_q, state_d;

  logic [NUM_CH-1:0] pending_q;
  logic [NUM_CH-1:0] is_nak_q;
  logic [NUM_CH-1:0] req_overrun_q;
  logic [7:0]        eid_q [NUM_CH];

  logic [7:0]        frame_eid_q;
  logic              frame_nak_q;
  logic [CH_W-1:0]   frame_ch_q;
  logic [CH_W-1:0]   last_grant_q;

  logic              grant_found;
  logic [CH_W-1:0]   grant_idx;
  logic [NUM_CH-1:0] grant_vec;
  logic              do_grant;

`ifdef RESP_NAK_CODE_EN
  logic [7:0]        code_q [NUM_CH];
  logic [7:0]        frame_code_q;
`else
  logic              unused_nak_code;
  assign unused_nak_code = ^nak_code_in;
`endif

  // Round-robin: first pending channel above last_grant, else first at or below it.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && pending_q[i] && (CH_W'(i) > last_grant_q)) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!grant_found && pending_q[i] && (CH_W'(i) <= last_grant_q)) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(i);
      end
    end
  end

  assign do_grant = (state_q == StIdle) && grant_found;

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      grant_vec[i] = do_grant && (grant_idx == CH_W'(i));
    end
  end

  // Per-channel request latch; a request on its own grant edge refills the slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= '0;
      is_nak_q      <= '0;
      req_overrun_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        eid_q[i] <= '0;
`ifdef RESP_NAK_CODE_EN
        code_q[i] <= '0;
`endif
      end
    end else begin
      req_overrun_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        if (generate_ack[i] || generate_nak[i]) begin
          if (pending_q[i] && !grant_vec[i]) begin
            req_overrun_q[i] <= 1'b1;
          end else begin
            pending_q[i] <= 1'b1;
            is_nak_q[i]  <= !generate_ack[i];
            eid_q[i]     <= eid_in[8*i +: 8];
`ifdef RESP_NAK_CODE_EN
            code_q[i]    <= nak_code_in[8*i +: 8];
`endif
          end
        end else if (grant_vec[i]) begin
          pending_q[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_eid_q  <= '0;
      frame_nak_q  <= 1'b0;
      frame_ch_q   <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
`ifdef RESP_NAK_CODE_EN
      frame_code_q <= '0;
`endif
    end else if (do_grant) begin
      frame_eid_q  <= eid_q[grant_idx];
      frame_nak_q  <= is_nak_q[grant_idx];
      frame_ch_q   <= grant_idx;
      last_grant_q <= grant_idx;
`ifdef RESP_NAK_CODE_EN
      frame_code_q <= code_q[grant_idx];
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (grant_found) state_d = StType;
      StType: if (message_data_ready) state_d = StEid;
      StEid:  if (message_data_ready) state_d = StLen;
      StLen: begin
        if (message_data_ready) begin
`ifdef RESP_NAK_CODE_EN
          state_d = frame_nak_q ? StCode : StIdle;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef RESP_NAK_CODE_EN
      StCode: if (message_data_ready) state_d = StIdle;
`endif
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    message_data       = 8'h00;
    message_data_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        message_data       = 8'h00;
        message_data_valid = 1'b0;
      end
      StType: begin
        message_data       = {7'b0, frame_nak_q};
        message_data_valid = 1'b1;
      end
      StEid: begin
        message_data       = frame_eid_q;
        message_data_valid = 1'b1;
      end
      StLen: begin
`ifdef RESP_NAK_CODE_EN
        message_data       = {7'b0, frame_nak_q};
`else
        message_data       = 8'h00;
`endif
        message_data_valid = 1'b1;
      end
`ifdef RESP_NAK_CODE_EN
      StCode: begin
        message_data       = frame_code_q;
        message_data_valid = 1'b1;
      end
`endif
      default: begin
        message_data       = 8'h00;
        message_data_valid = 1'b0;
      end
    endcase
  end

  assign message_frame_valid = message_data_valid;
  assign frame_channel       = frame_ch_q;
  assign ch_pending          = pending_q;
  assign req_overrun         = req_overrun_q;

endmodule

// File: tb/tb_resp_frame_generator.sv
// Directed self-checking bench for resp_frame_generator (NUM_CH=2).
// Honours RESP_NAK_CODE_EN when computing expected NAK frames.
module tb_resp_frame_generator;

  localparam int unsigned NUM_CH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  generate_ack;
  logic [1:0]  generate_nak;
  logic [15:0] eid_in;
  logic [15:0] nak_code_in;
  logic        message_data_ready;
  logic [7:0]  message_data;
  logic        message_data_valid;
  logic        message_frame_valid;
  logic [0:0]  frame_channel;
  logic [1:0]  ch_pending;
  logic [1:0]  req_overrun;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got [8];
  int         got_n;
  int         got_ch;
  int         got_fv;

  always #5 clk = ~clk;

  resp_frame_generator #(.NUM_CH(NUM_CH)) dut (
    .clk                 (clk),
    .reset               (reset),
    .generate_ack        (generate_ack),
    .generate_nak        (generate_nak),
    .eid_in              (eid_in),
    .nak_code_in         (nak_code_in),
    .message_data_ready  (message_data_ready),
    .message_data        (message_data),
    .message_data_valid  (message_data_valid),
    .message_frame_valid (message_frame_valid),
    .frame_channel       (frame_channel),
    .ch_pending          (ch_pending),
    .req_overrun         (req_overrun)
  );

  // Drive a one-cycle request at the current negedge; returns one negedge later.
  task automatic pulse(input int ch, input bit ack, input bit nak,
                       input logic [7:0] eid, input logic [7:0] code);
    generate_ack[ch]       = ack;
    generate_nak[ch]       = nak;
    eid_in[8*ch +: 8]      = eid;
    nak_code_in[8*ch +: 8] = code;
    @(negedge clk);
    generate_ack = '0;
    generate_nak = '0;
  endtask

  // Record accepted bytes of the next frame (ready assumed high), bounded wait.
  task automatic collect_frame();
    int budget;
    got_n  = 0;
    got_ch = -1;
    got_fv = 0;
    budget = 0;
    while (!message_data_valid && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (message_data_valid) got_ch = int'(frame_channel);
    while (message_data_valid && got_n < 8) begin
      if (message_frame_valid) got_fv++;
      if (message_data_ready) begin
        got[got_n] = message_data;
        got_n++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (message_data !== 8'h00 || message_data_valid !== 1'b0 || message_frame_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: got data=%h v=%b fv=%b want 00/0/0",
               message_data, message_data_valid, message_frame_valid);
    end
    checks++;
    if (frame_channel !== 1'b0 || ch_pending !== 2'b00 || req_overrun !== 2'b00) begin
      failures++;
      $display("FAIL reset_ctl: got ch=%b pend=%b ovr=%b want 0/00/00",
               frame_channel, ch_pending, req_overrun);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_ack();
    logic [7:0] exp [3];
    exp = '{8'h00, 8'h5A, 8'h00};
    pulse(0, 1'b1, 1'b0, 8'h5A, 8'h00);
    checks++;
    if (ch_pending !== 2'b01 || message_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL ack_latch: got pend=%b v=%b want 01/0", ch_pending, message_data_valid);
    end
    @(negedge clk);
    checks++;
    if (message_data_valid !== 1'b1 || ch_pending !== 2'b00) begin
      failures++;
      $display("FAIL ack_latency: got v=%b pend=%b want 1/00", message_data_valid, ch_pending);
    end
    collect_frame();
    checks++;
    if (got_n !== 3 || got_fv !== 3 || got_ch !== 0) begin
      failures++;
      $display("FAIL ack_shape: got n=%0d fv=%0d ch=%0d want 3/3/0", got_n, got_fv, got_ch);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got[k] !== exp[k]) begin
        failures++;
        $display("FAIL ack_byte%0d: got %h want %h", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_nak();
    logic [7:0] exp [4];
    int exp_n;
`ifdef RESP_NAK_CODE_EN
    exp   = '{8'h01, 8'h33, 8'h01, 8'hE2};
    exp_n = 4;
`else
    exp   = '{8'h01, 8'h33, 8'h00, 8'h00};
    exp_n = 3;
`endif
    pulse(1, 1'b0, 1'b1, 8'h33, 8'hE2);
    collect_frame();
    checks++;
    if (got_n !== exp_n || got_ch !== 1) begin
      failures++;
      $display("FAIL nak_shape: got n=%0d ch=%0d want %0d/1", got_n, got_ch, exp_n);
    end
    for (int k = 0; k < exp_n; k++) begin
      checks++;
      if (got[k] !== exp[k]) begin
        failures++;
        $display("FAIL nak_byte%0d: got %h want %h", k, got[k], exp[k]);
      end
    end
  endtask

  task automatic test_alternate();
    int         exp_ch  [4];
    logic [7:0] exp_eid [4];
    exp_ch  = '{0, 1, 0, 1};
    exp_eid = '{8'h10, 8'h11, 8'h20, 8'h21};
    generate_ack   = 2'b11;
    eid_in         = 16'h1110;
    @(negedge clk);
    generate_ack   = '0;
    for (int f = 0; f < 4; f++) begin
      collect_frame();
      checks++;
      if (got_ch !== exp_ch[f] || got[1] !== exp_eid[f] || got_n !== 3) begin
        failures++;
        $display("FAIL alt_frame%0d: got ch=%0d eid=%h n=%0d want ch=%0d eid=%h n=3",
                 f, got_ch, got[1], got_n, exp_ch[f], exp_eid[f]);
      end
      if (f < 2) pulse(f, 1'b1, 1'b0, exp_eid[f] + 8'h10, 8'h00);
    end
  endtask

  task automatic test_overrun();
    message_data_ready = 1'b0;
    pulse(1, 1'b1, 1'b0, 8'h01, 8'h00);
    @(negedge clk);
    pulse(0, 1'b1, 1'b0, 8'h44, 8'h00);
    checks++;
    if (req_overrun !== 2'b00 || ch_pending !== 2'b01) begin
      failures++;
      $display("FAIL ovr_first: got ovr=%b pend=%b want 00/01", req_overrun, ch_pending);
    end
    pulse(0, 1'b1, 1'b0, 8'h77, 8'h00);
    checks++;
    if (req_overrun !== 2'b01) begin
      failures++;
      $display("FAIL ovr_pulse: got %b want 01", req_overrun);
    end
    @(negedge clk);
    checks++;
    if (req_overrun !== 2'b00) begin
      failures++;
      $display("FAIL ovr_width: got %b want 00", req_overrun);
    end
    message_data_ready = 1'b1;
    collect_frame();
    checks++;
    if (got_ch !== 1 || got[1] !== 8'h01) begin
      failures++;
      $display("FAIL ovr_busy_frame: got ch=%0d eid=%h want 1/01", got_ch, got[1]);
    end
    collect_frame();
    checks++;
    if (got_ch !== 0 || got[1] !== 8'h44 || got_n !== 3) begin
      failures++;
      $display("FAIL ovr_kept_eid: got ch=%0d eid=%h n=%0d want 0/44/3", got_ch, got[1], got_n);
    end
    pulse(0, 1'b1, 1'b1, 8'h55, 8'hCC);
    collect_frame();
    checks++;
    if (got[0] !== 8'h00 || got[1] !== 8'h55 || got_n !== 3) begin
      failures++;
      $display("FAIL ack_wins: got type=%h eid=%h n=%0d want 00/55/3", got[0], got[1], got_n);
    end
  endtask

  task automatic test_ready_toggle();
    logic       pat  [6];
    logic       expv [6];
    logic [7:0] expd [6];
    pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    expv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    expd = '{8'h00, 8'hA5, 8'hA5, 8'hA5, 8'h00, 8'h00};
    message_data_ready = 1'b1;
    pulse(0, 1'b1, 1'b0, 8'hA5, 8'h00);
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      message_data_ready = pat[c];
      #1;
      checks++;
      if (message_data_valid !== expv[c] || message_data !== expd[c] ||
          (expv[c] && frame_channel !== 1'b0)) begin
        failures++;
        $display("FAIL rdy_cycle%0d: got v=%b d=%h ch=%b want v=%b d=%h ch=0",
                 c, message_data_valid, message_data, frame_channel, expv[c], expd[c]);
      end
      @(negedge clk);
    end
    message_data_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    pulse(0, 1'b1, 1'b0, 8'h66, 8'h00);
    @(negedge clk);
    pulse(1, 1'b1, 1'b0, 8'h12, 8'h00);
    checks++;
    if (message_data !== 8'h66 || ch_pending !== 2'b10) begin
      failures++;
      $display("FAIL rst_pre: got d=%h pend=%b want 66/10", message_data, ch_pending);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (message_data !== 8'h00 || message_data_valid !== 1'b0 || message_frame_valid !== 1'b0 ||
        frame_channel !== 1'b0 || ch_pending !== 2'b00 || req_overrun !== 2'b00) begin
      failures++;
      $display("FAIL rst_mid: got d=%h v=%b fv=%b ch=%b pend=%b ovr=%b want all 0",
               message_data, message_data_valid, message_frame_valid, frame_channel,
               ch_pending, req_overrun);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (message_data_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_no_resume: got v=%b want 0", message_data_valid);
    end
    pulse(1, 1'b1, 1'b0, 8'h99, 8'h00);
    collect_frame();
    checks++;
    if (got_n !== 3 || got_ch !== 1 || got[0] !== 8'h00 || got[1] !== 8'h99 || got[2] !== 8'h00) begin
      failures++;
      $display("FAIL rst_after: got n=%0d ch=%0d %h %h %h want 3/1 00 99 00",
               got_n, got_ch, got[0], got[1], got[2]);
    end
  endtask

  initial begin
    reset              = 1'b1;
    generate_ack       = '0;
    generate_nak       = '0;
    eid_in             = '0;
    nak_code_in        = '0;
    message_data_ready = 1'b1;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_ack();
    test_nak();
    test_alternate();
    test_overrun();
    test_ready_toggle();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
